// File: rtl/fp_multiplier_param.sv
// fp_multiplier_param: multicycle floating-point multiplier with generic
// exponent/mantissa widths. Round-to-nearest-even, subnormal inputs and
// results flushed to zero. Exception flags port enabled by FPMUL_FLAGS_EN.
module fp_multiplier_param #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ready,
  input  logic [EXP_W+MAN_W:0]   op1,
  input  logic [EXP_W+MAN_W:0]   op2,
  output logic [EXP_W+MAN_W:0]   res,
  output logic                   done,
  output logic                   busy
`ifdef FPMUL_FLAGS_EN
  ,
  output logic [3:0]             flags
`endif
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int PW = 2 * MAN_W + 2;
  localparam int XW = EXP_W + 2;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLASS = 3'd1;
  localparam logic [2:0] S_MUL   = 3'd2;
  localparam logic [2:0] S_NORM  = 3'd3;
  localparam logic [2:0] S_ROUND = 3'd4;
  localparam logic [2:0] S_PACK  = 3'd5;

  localparam logic signed [XW-1:0] BIAS     = $signed({3'b000, {(EXP_W-1){1'b1}}});
  localparam logic signed [XW-1:0] EXP_MAX  = $signed({2'b00, {EXP_W{1'b1}}});
  localparam logic signed [XW-1:0] EXP_ZERO = '0;
  localparam logic signed [XW-1:0] EXP_ONE  = $signed({{(XW-1){1'b0}}, 1'b1});
  localparam logic [W-1:0]         QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  logic [2:0]              state_q, state_d;
  logic [W-1:0]            a_q, a_d, b_q, b_d;
  logic                    spec_q, spec_d;
  logic [W-1:0]            spec_res_q, spec_res_d;
  logic [PW-1:0]           prod_q, prod_d;
  logic signed [XW-1:0]    exp_q, exp_d;
  logic [MAN_W-1:0]        man_q, man_d;
  logic [W-1:0]            res_q, res_d;
  logic                    done_q, done_d;
`ifdef FPMUL_FLAGS_EN
  logic                    spec_inv_q, spec_inv_d;
  logic                    inexact_q, inexact_d;
  logic [3:0]              flags_q, flags_d;
`endif

  // Operand fields of the latched operands
  logic                    s1, s2, sgn;
  logic [EXP_W-1:0]        e1, e2;
  logic [MAN_W-1:0]        m1, m2;
  assign {s1, e1, m1} = a_q;
  assign {s2, e2, m2} = b_q;
  assign sgn = s1 ^ s2;

  // Classification; exp==0 counts as zero whatever the mantissa
  logic nan1, nan2, inf1, inf2, zero1, zero2, invalid, special;
  assign nan1    = (&e1) & (|m1);
  assign nan2    = (&e2) & (|m2);
  assign inf1    = (&e1) & ~(|m1);
  assign inf2    = (&e2) & ~(|m2);
  assign zero1   = ~(|e1);
  assign zero2   = ~(|e2);
  assign invalid = nan1 | nan2 | (zero1 & inf2) | (inf1 & zero2);
  assign special = nan1 | nan2 | inf1 | inf2 | zero1 | zero2;

  // Significand product and biased exponent sum
  logic [PW-1:0]        prod_mul;
  logic signed [XW-1:0] exp_mul;
  assign prod_mul = {{(MAN_W+1){1'b0}}, 1'b1, m1} * {{(MAN_W+1){1'b0}}, 1'b1, m2};
  assign exp_mul  = $signed({2'b00, e1}) + $signed({2'b00, e2}) - BIAS;

  // Rounding: leading one sits at prod_q[PW-1] once normalised
  logic [MAN_W-1:0] mant_raw, mant_rnd;
  logic             g_bit, r_bit, s_bit, rnd_up, rnd_carry;
  assign mant_raw = prod_q[PW-2 -: MAN_W];
  assign g_bit    = prod_q[MAN_W];
  assign r_bit    = prod_q[MAN_W-1];
  assign s_bit    = |prod_q[MAN_W-2:0];
  assign rnd_up   = g_bit & (r_bit | s_bit | mant_raw[0]);
  assign {rnd_carry, mant_rnd} = {1'b0, mant_raw} + {{MAN_W{1'b0}}, rnd_up};

  // Range checks on the final exponent
  logic ovf, unf;
  assign ovf = (exp_q >= EXP_MAX);
  assign unf = (exp_q <= EXP_ZERO);

  // Next-state and datapath sequencing
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    spec_d     = spec_q;
    spec_res_d = spec_res_q;
    prod_d     = prod_q;
    exp_d      = exp_q;
    man_d      = man_q;
    res_d      = res_q;
    done_d     = 1'b0;
`ifdef FPMUL_FLAGS_EN
    spec_inv_d = spec_inv_q;
    inexact_d  = inexact_q;
    flags_d    = flags_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (ready) begin
          a_d     = op1;
          b_d     = op2;
          state_d = S_CLASS;
        end
      end
      S_CLASS: begin
        spec_d = special;
        if (invalid)
          spec_res_d = QNAN;
        else if (zero1 | zero2)
          spec_res_d = {sgn, {(W-1){1'b0}}};
        else
          spec_res_d = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
`ifdef FPMUL_FLAGS_EN
        spec_inv_d = invalid;
`endif
        state_d = special ? S_PACK : S_MUL;
      end
      S_MUL: begin
        prod_d  = prod_mul;
        exp_d   = exp_mul;
        state_d = S_NORM;
      end
      S_NORM: begin
        if (prod_q[PW-1])
          exp_d = exp_q + EXP_ONE;
        else
          prod_d = prod_q << 1;
        state_d = S_ROUND;
      end
      S_ROUND: begin
        man_d = mant_rnd;
        exp_d = exp_q + (rnd_carry ? EXP_ONE : EXP_ZERO);
`ifdef FPMUL_FLAGS_EN
        inexact_d = g_bit | r_bit | s_bit;
`endif
        state_d = S_PACK;
      end
      S_PACK: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
        if (spec_q) begin
          res_d = spec_res_q;
`ifdef FPMUL_FLAGS_EN
          flags_d = {spec_inv_q, 3'b000};
`endif
        end else if (ovf) begin
          res_d = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
`ifdef FPMUL_FLAGS_EN
          flags_d = 4'b0101;
`endif
        end else if (unf) begin
          res_d = {sgn, {(W-1){1'b0}}};
`ifdef FPMUL_FLAGS_EN
          flags_d = 4'b0011;
`endif
        end else begin
          res_d = {sgn, exp_q[EXP_W-1:0], man_q};
`ifdef FPMUL_FLAGS_EN
          flags_d = {3'b000, inexact_q};
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      spec_q     <= 1'b0;
      spec_res_q <= '0;
      prod_q     <= '0;
      exp_q      <= '0;
      man_q      <= '0;
      res_q      <= '0;
      done_q     <= 1'b0;
`ifdef FPMUL_FLAGS_EN
      spec_inv_q <= 1'b0;
      inexact_q  <= 1'b0;
      flags_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      spec_q     <= spec_d;
      spec_res_q <= spec_res_d;
      prod_q     <= prod_d;
      exp_q      <= exp_d;
      man_q      <= man_d;
      res_q      <= res_d;
      done_q     <= done_d;
`ifdef FPMUL_FLAGS_EN
      spec_inv_q <= spec_inv_d;
      inexact_q  <= inexact_d;
      flags_q    <= flags_d;
`endif
    end
  end

  assign res  = res_q;
  assign done = done_q;
  assign busy = (state_q != S_IDLE);
`ifdef FPMUL_FLAGS_EN
  assign flags = flags_q;
`endif

endmodule

// File: tb/tb_fp_multiplier_param.sv
// Bench for fp_multiplier_param: single-precision and half-precision instances.
module tb_fp_multiplier_param;

  logic        clk, rst;
  logic        ready, done, busy;
  logic [31:0] op1, op2, res;
  logic        h_ready, h_done, h_busy;
  logic [15:0] h_op1, h_op2, h_res;
`ifdef FPMUL_FLAGS_EN
  logic [3:0]  flags, h_flags;
`endif

  int n_cmp, n_fail;

  fp_multiplier_param #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst(rst), .ready(ready), .op1(op1), .op2(op2),
    .res(res), .done(done), .busy(busy)
`ifdef FPMUL_FLAGS_EN
    , .flags(flags)
`endif
  );

  fp_multiplier_param #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .rst(rst), .ready(h_ready), .op1(h_op1), .op2(h_op2),
    .res(h_res), .done(h_done), .busy(h_busy)
`ifdef FPMUL_FLAGS_EN
    , .flags(h_flags)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: exact integer product, rounded to nearest-even by remainder
  function automatic void ref_mul(input logic [31:0] a, input logic [31:0] b,
                                  input int ew, input int mw,
                                  output logic [31:0] r, output logic [3:0] fl,
                                  output int lat);
    longint emax, bias, ea, eb, ma, mb, sa, sb, s, p, e, q, rem, half;
    int msb, k;
    bit nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    emax = (longint'(1) << ew) - 1;
    bias = (longint'(1) << (ew - 1)) - 1;
    ea = (longint'(a) >> mw) & emax;
    eb = (longint'(b) >> mw) & emax;
    ma = longint'(a) & ((longint'(1) << mw) - 1);
    mb = longint'(b) & ((longint'(1) << mw) - 1);
    sa = (longint'(a) >> (ew + mw)) & 1;
    sb = (longint'(b) >> (ew + mw)) & 1;
    s  = sa ^ sb;
    nan_a = (ea == emax) && (ma != 0);  nan_b = (eb == emax) && (mb != 0);
    inf_a = (ea == emax) && (ma == 0);  inf_b = (eb == emax) && (mb == 0);
    zero_a = (ea == 0);                 zero_b = (eb == 0);
    if (nan_a || nan_b || (zero_a && inf_b) || (inf_a && zero_b)) begin
      r = 32'((emax << mw) | (longint'(1) << (mw - 1))); fl = 4'b1000; lat = 2;
    end else if (zero_a || zero_b) begin
      r = 32'(s << (ew + mw)); fl = 4'b0000; lat = 2;
    end else if (inf_a || inf_b) begin
      r = 32'((s << (ew + mw)) | (emax << mw)); fl = 4'b0000; lat = 2;
    end else begin
      lat = 5;
      p = ((longint'(1) << mw) | ma) * ((longint'(1) << mw) | mb);
      msb = ((p >> (2 * mw + 1)) != 0) ? 2 * mw + 1 : 2 * mw;
      e = ea + eb - bias + longint'(msb - 2 * mw);
      k = msb - mw;
      q = p >> k;
      rem = p & ((longint'(1) << k) - 1);
      half = longint'(1) << (k - 1);
      if (rem > half || (rem == half && (q & 1) == 1)) q = q + 1;
      if (q == (longint'(1) << (mw + 1))) begin q = q >> 1; e = e + 1; end
      if (e >= emax) begin
        r = 32'((s << (ew + mw)) | (emax << mw)); fl = 4'b0101;
      end else if (e <= 0) begin
        r = 32'(s << (ew + mw)); fl = 4'b0011;
      end else begin
        r = 32'((s << (ew + mw)) | (e << mw) | (q - (longint'(1) << mw)));
        fl = {3'b000, rem != 0};
      end
    end
  endfunction

  function automatic logic [31:0] rnd_op(input int ew, input int mw);
    longint emax, bias, e, m, s;
    int sel;
    emax = (longint'(1) << ew) - 1;
    bias = (longint'(1) << (ew - 1)) - 1;
    sel  = int'($urandom_range(0, 15));
    m    = longint'($urandom) & ((longint'(1) << mw) - 1);
    s    = longint'($urandom_range(0, 1));
    if (sel == 0)       e = 0;
    else if (sel == 1)  e = emax;
    else if (sel == 2)  begin e = emax; m = 0; end
    else if (sel == 3)  e = longint'($urandom_range(1, 32'(emax - 1)));
    else                e = longint'($urandom_range(32'(bias / 2), 32'(bias + bias / 2)));
    if (sel == 4 || sel == 5) m = m & ~((longint'(1) << (mw - 4)) - 1);
    return 32'((s << (ew + mw)) | (e << mw) | m);
  endfunction

  // One operation on either instance; bounded wait for done
  task automatic run_op(input bit h, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic [3:0] f,
                        output int lat, output bit busy_ok);
    @(negedge clk);
    if (h) begin h_op1 = a[15:0]; h_op2 = b[15:0]; h_ready = 1'b1; end
    else   begin op1 = a; op2 = b; ready = 1'b1; end
    @(posedge clk); #1;
    ready = 1'b0; h_ready = 1'b0;
    lat = 0; busy_ok = 1'b1;
    while (!(h ? h_done : done) && lat < 20) begin
      if (!(h ? h_busy : busy)) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (h ? h_busy : busy) busy_ok = 1'b0;
    r = h ? {16'h0, h_res} : res;
`ifdef FPMUL_FLAGS_EN
    f = h ? h_flags : flags;
`else
    f = 4'b0000;
`endif
  endtask

  typedef struct {
    string       name;
    logic [31:0] a, b, r;
    logic [3:0]  fl;
    int          lat;
  } vec_t;

  vec_t tbl [10];

  initial begin
    logic [31:0] r, a, b, mr;
    logic [3:0]  f, mf;
    int          lat, ml;
    bit          bok;

    n_cmp = 0; n_fail = 0;
    rst = 1'b1; ready = 1'b0; op1 = '0; op2 = '0;
    h_ready = 1'b0; h_op1 = '0; h_op2 = '0;

    tbl[0] = '{"mul_3x2p5",   32'h40400000, 32'h40200000, 32'h40F00000, 4'b0000, 5};
    tbl[1] = '{"tie_even",    32'h3F800800, 32'h3F800800, 32'h3F801000, 4'b0001, 5};
    tbl[2] = '{"zero_x_inf",  32'h00000000, 32'h7F800000, 32'h7FC00000, 4'b1000, 2};
    tbl[3] = '{"neg_x_inf",   32'hC0000000, 32'h7F800000, 32'hFF800000, 4'b0000, 2};
    tbl[4] = '{"overflow",    32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0101, 5};
    tbl[5] = '{"underflow",   32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011, 5};
    tbl[6] = '{"nan_in",      32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b1000, 2};
    tbl[7] = '{"subnorm_ftz", 32'h3F800000, 32'h00400000, 32'h00000000, 4'b0000, 2};
    tbl[8] = '{"neg_product", 32'hC0400000, 32'h40200000, 32'hC0F00000, 4'b0000, 5};
    tbl[9] = '{"sticky_lsb",  32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001, 5};

    repeat (2) @(posedge clk); #1;
    chk("rst_res", res, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_h_res", h_res, 0);
`ifdef FPMUL_FLAGS_EN
    chk("rst_flags", flags, 0);
`endif
    @(negedge clk); rst = 1'b0;

    // Directed table
    for (int i = 0; i < 10; i++) begin
      run_op(1'b0, tbl[i].a, tbl[i].b, r, f, lat, bok);
      chk({tbl[i].name, "_res"}, r, tbl[i].r);
      chk({tbl[i].name, "_lat"}, lat, tbl[i].lat);
      chk({tbl[i].name, "_busy"}, bok, 1);
`ifdef FPMUL_FLAGS_EN
      chk({tbl[i].name, "_flags"}, f, tbl[i].fl);
`endif
      ref_mul(tbl[i].a, tbl[i].b, 8, 23, mr, mf, ml);
      chk({tbl[i].name, "_model"}, r, mr);
      @(posedge clk); #1;
      chk({tbl[i].name, "_done_pulse"}, done, 0);
    end

    // ready held while busy is ignored, not queued
    @(negedge clk); op1 = 32'h40400000; op2 = 32'h40200000; ready = 1'b1;
    @(posedge clk); #1;
    op1 = 32'h3F800000; op2 = 32'h3F800000;
    repeat (2) @(posedge clk); #1;
    ready = 1'b0; lat = 2;
    while (!done && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("busy_ready_lat", lat, 5);
    chk("busy_ready_res", res, 32'h40F00000);
    @(posedge clk); #1;
    chk("busy_ready_no_queue", busy, 0);

    // Half precision, back-to-back start in the done cycle
    @(negedge clk); h_op1 = 16'h4200; h_op2 = 16'h4100; h_ready = 1'b1;
    @(posedge clk); #1;
    h_ready = 1'b0; lat = 0;
    while (!h_done && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("half_lat", lat, 5);
    chk("half_res", h_res, 16'h4780);
    h_op1 = 16'h3C00; h_op2 = 16'h3C00; h_ready = 1'b1;
    @(posedge clk); #1;
    h_ready = 1'b0;
    chk("b2b_busy", h_busy, 1);
    chk("b2b_done_low", h_done, 0);
    lat = 0;
    while (!h_done && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("b2b_lat", lat, 5);
    chk("b2b_res", h_res, 16'h3C00);

    // Asynchronous reset while in MUL
    @(negedge clk); op1 = 32'h40400000; op2 = 32'h40200000; ready = 1'b1;
    @(posedge clk); #1; ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; #1;
    chk("midrst_res", res, 0);
    chk("midrst_done", done, 0);
    chk("midrst_busy", busy, 0);
`ifdef FPMUL_FLAGS_EN
    chk("midrst_flags", flags, 0);
`endif
    @(negedge clk); rst = 1'b0;
    run_op(1'b0, 32'h3F800000, 32'h3F800000, r, f, lat, bok);
    chk("after_rst_res", r, 32'h3F800000);
    chk("after_rst_lat", lat, 5);

    // Randomised single precision against the model
    for (int i = 0; i < 200; i++) begin
      a = rnd_op(8, 23); b = rnd_op(8, 23);
      ref_mul(a, b, 8, 23, mr, mf, ml);
      run_op(1'b0, a, b, r, f, lat, bok);
      chk($sformatf("rnd32_%0d_res(%h*%h)", i, a, b), r, mr);
      chk($sformatf("rnd32_%0d_lat", i), lat, ml);
`ifdef FPMUL_FLAGS_EN
      chk($sformatf("rnd32_%0d_flags", i), f, mf);
`endif
    end

    // Randomised half precision against the model
    for (int i = 0; i < 100; i++) begin
      a = rnd_op(5, 10); b = rnd_op(5, 10);
      ref_mul(a, b, 5, 10, mr, mf, ml);
      run_op(1'b1, a, b, r, f, lat, bok);
      chk($sformatf("rnd16_%0d_res(%h*%h)", i, a[15:0], b[15:0]), r, mr);
      chk($sformatf("rnd16_%0d_lat", i), lat, ml);
`ifdef FPMUL_FLAGS_EN
      chk($sformatf("rnd16_%0d_flags", i), f, mf);
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_multiplier_param.md
# fp_multiplier_param

Parametrised IEEE-754-style floating-point multiplier with configurable exponent and mantissa widths. It generalises the single-precision multicycle multiplier to any EXP_W/MAN_W format, with correct round-to-nearest-even, flush-to-zero subnormal handling, a busy indicator and optional exception flags. It sits in the arithmetic datapath as a multicycle unit started by a `ready` pulse, and reports completion with a one-cycle `done` pulse.

## Interface
- EXP_W, 8: exponent field width (≥3). Bias B = 2^(EXP_W-1)-1.
- MAN_W, 23: stored mantissa field width (≥4). Word width W = 1+EXP_W+MAN_W.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous and active-high.
- ready  in  1  start request; sampled only in IDLE.
- op1  in  W  operand 1 {sign, exp, man}; latched when a start is accepted.
- op2  in  W  operand 2; latched when a start is accepted.
- res  out  W  result register; holds its value until the next completion.
- done  out  1  one-cycle completion pulse, coincident with the `res` update.
- busy  out  1  high whenever the state is not IDLE.
- flags  out  4  {invalid, overflow, underflow, inexact}; present only with FPMUL_FLAGS_EN.

## Operation
- Reset values: state IDLE; res=0; done=0; busy=0; flags=0. Internal operand and product registers are cleared.
- States and transitions:
  - IDLE: if ready=1, go to CLASS; otherwise stay in IDLE.
  - CLASS: classify both operands. Special case → PACK; otherwise → MUL.
  - MUL → NORM → ROUND → PACK → IDLE.
  - Illegal state encoding → IDLE.
- Operand classification:
  - exp all ones, man = 0: INF.
  - exp all ones, man ≠ 0: NaN.
  - exp = 0 (any man): ZERO. Subnormal inputs are flushed to zero.
  - Otherwise: NUM.
- Special-case results:
  - Any NaN, or ZERO×INF: canonical NaN = {0, all ones, 1, 0…}. Sets invalid.
  - Else any ZERO: signed zero.
  - Else any INF: signed infinity.
  - Sign of zero and infinity results = s1^s2.
- MUL:
  - Product P = {1,m1}×{1,m2}, width 2·MAN_W+2, unsigned.
  - Exponent E = e1+e2−B, computed in EXP_W+2 bits signed.
- NORM: if the P MSB is set, E = E+1 and the product is used as-is; otherwise shift P left by 1.
- ROUND (round to nearest, ties to even):
  - Mantissa = the MAN_W bits below the leading one.
  - G = next bit; R = the bit after G; S = OR of all remaining bits.
  - Increment the mantissa if G & (R | S | LSB).
  - If the increment carries out of the mantissa, mantissa = 0 and E = E+1.
  - inexact = G|R|S.
- PACK:
  - If E ≥ 2^EXP_W−1: signed infinity. Sets overflow and inexact.
  - If E ≤ 0: signed zero, flush-to-zero. Sets underflow and inexact.
  - Otherwise: {s1^s2, E[EXP_W-1:0], mantissa}.
  - res, done=1 and flags are written on the PACK→IDLE edge.
- `ready` asserted while busy is ignored. It is not queued.

## Timing
- Accepting edge: the rising edge at which state=IDLE and ready=1.
- Normal path: done rises 5 edges after the accepting edge.
- Special-case path: done rises 2 edges after the accepting edge.
- done is high for exactly one cycle.
- busy rises on the accepting edge and falls on the edge that asserts done.
- Back-to-back operation: ready=1 during the done cycle is accepted on that cycle's closing edge, with no bubble.
- Reset mid-operation: the unit immediately returns to IDLE with res=0, done=0, busy=0 and flags=0. The in-flight operation is discarded. The first edge after reset deassertion may accept a new start.

## Configuration
- FPMUL_FLAGS_EN defined:
  - The `flags` port exists.
  - flags is updated together with res on each completion and held until the next one.
  - Special cases other than invalid write 0 to flags.
- FPMUL_FLAGS_EN undefined:
  - The `flags` port and all flag logic are absent.
  - res, done, busy and timing are unchanged.

## Test plan
- Default widths: 0x40400000 × 0x40200000 (3.0×2.5) → res=0x40F00000; done exactly 5 edges after accept; busy high for those 5 cycles; flags=0000.
- Tie to even: 0x3F800800 × 0x3F800800 → res=0x3F801000 (rounded down to the even mantissa); inexact=1.
- Specials: 0x00000000 × 0x7F800000 → 0x7FC00000 with invalid=1, done 2 edges after accept. 0xC0000000 × 0x7F800000 → 0xFF800000.
- Overflow/underflow: 0x7F000000 × 0x40000000 → 0x7F800000 with overflow=1. 0x00800000 × 0x3F000000 → 0x00000000 with underflow=1.
- Half-precision instance (EXP_W=5, MAN_W=10): 0x4200 × 0x4100 → 0x4780. A second start with ready=1 in the done cycle completes 5 edges later.
- Reset in MUL state: pulse rst → res=0, done=0, busy=0 asynchronously. Then 0x3F800000 × 0x3F800000 → 0x3F800000.
